seg7_scan_driver: RTL and testbench

//  Consumes the BCD score digits (fenshu2/1/0) and the life digit (shengming) from the bcd converter.

---
 rtl/seg7_pkg.sv | 48 ++++
 rtl/seg7_decode.sv | 20 ++
 rtl/seg7_scan_driver.sv | 155 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared encodings for the 7-segment scan driver: FSM states, digit positions,
// and the active-low {g,f,e,d,c,b,a} segment patterns.
package seg7_pkg;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;
  localparam logic [1:0] DIG_LIFE = 2'd3;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  // Codes 10-15 are not BCD; show a dash so corrupt data is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder with a blanking override.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank wins over the decoded pattern.
  always_comb begin
    seg = SEG_OFF;
    if (blank) begin
      seg = SEG_OFF;
    end else begin
      seg = bcd_to_seg(bcd);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode scan driver with ghost blanking and a frame-coherent
// input latch. Optional macro LEADING_ZERO_BLANK_EN darkens leading score zeros.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] fenshu2,
  input  logic [3:0] fenshu1,
  input  logic [3:0] fenshu0,
  input  logic [3:0] shengming,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int PW      = $clog2(CNT_MAX);
  localparam logic [PW-1:0] SHOW_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  state_t        state_r;
  logic [1:0]    idx_r;
  logic [PW-1:0] presc_r;
  logic          restart_r;
  logic          en_q_r;
  logic [3:0]    sh_f2_r;
  logic [3:0]    sh_f1_r;
  logic [3:0]    sh_f0_r;
  logic [3:0]    sh_life_r;
  logic          blank_end_s;
  logic          capture_s;
  logic          dark_s;
  logic [3:0]    digit_s;
  logic [6:0]    seg_dec_s;

  // After reset or re-enable, the first blank leads into ones (no idx step).
  assign blank_end_s = (state_r == ST_BLANK) && (presc_r == BLANK_LAST);
  assign capture_s   = en && (!en_q_r ||
                              (blank_end_s && (restart_r || (idx_r == DIG_LIFE))));

  // Select the latched digit for the active position and its leading-zero policy.
  always_comb begin
    digit_s = sh_f0_r;
    dark_s  = 1'b0;
    case (idx_r)
      DIG_ONES: digit_s = sh_f0_r;
      DIG_TENS: digit_s = sh_f1_r;
      DIG_HUND: digit_s = sh_f2_r;
      DIG_LIFE: digit_s = sh_life_r;
      default:  digit_s = sh_f0_r;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_r == DIG_HUND) begin
      dark_s = (sh_f2_r == 4'd0);
    end else if (idx_r == DIG_TENS) begin
      dark_s = (sh_f2_r == 4'd0) && (sh_f1_r == 4'd0);
    end else begin
      dark_s = 1'b0;
    end
`else
    dark_s = 1'b0;
`endif
  end

  seg7_decode u_decode (
    .bcd   (digit_s),
    .blank (dark_s),
    .seg   (seg_dec_s)
  );

  // Scan FSM: prescaler, digit index and registered pin drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_BLANK;
      idx_r     <= DIG_ONES;
      presc_r   <= '0;
      restart_r <= 1'b1;
      en_q_r    <= 1'b0;
      an        <= 4'b1111;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
    end else if (!en) begin
      state_r   <= ST_BLANK;
      idx_r     <= DIG_ONES;
      presc_r   <= '0;
      restart_r <= 1'b1;
      en_q_r    <= 1'b0;
      an        <= 4'b1111;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
    end else begin
      en_q_r <= 1'b1;
      case (state_r)
        ST_SHOW: begin
          if (presc_r == SHOW_LAST) begin
            state_r <= ST_BLANK;
            presc_r <= '0;
          end else begin
            presc_r <= presc_r + PRESC_ONE;
          end
          an  <= ~(4'b0001 << idx_r);
          seg <= seg_dec_s;
          dp  <= (idx_r == DIG_LIFE) ? 1'b0 : 1'b1;
        end
        ST_BLANK: begin
          if (blank_end_s) begin
            state_r   <= ST_SHOW;
            presc_r   <= '0;
            restart_r <= 1'b0;
            idx_r     <= restart_r ? DIG_ONES : (idx_r + 2'd1);
          end else begin
            presc_r <= presc_r + PRESC_ONE;
          end
          an  <= 4'b1111;
          seg <= SEG_OFF;
          dp  <= 1'b1;
        end
        default: begin
          state_r <= ST_BLANK;
          presc_r <= '0;
          an      <= 4'b1111;
          seg     <= SEG_OFF;
          dp      <= 1'b1;
        end
      endcase
    end
  end

  // Frame latch: inputs are sampled only at frame start or on (re)enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_f2_r   <= 4'd0;
      sh_f1_r   <= 4'd0;
      sh_f0_r   <= 4'd0;
      sh_life_r <= 4'd0;
    end else if (capture_s) begin
      sh_f2_r   <= fenshu2;
      sh_f1_r   <= fenshu1;
      sh_f0_r   <= fenshu0;
      sh_life_r <= shengming;
    end else begin
      sh_f2_r   <= sh_f2_r;
      sh_f1_r   <= sh_f1_r;
      sh_f0_r   <= sh_f0_r;
      sh_life_r <= sh_life_r;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (REFRESH_DIV=4, BLANK_CYC=2): checks
// every output cycle of each scan phase against hand-derived patterns.
module tb_seg7_scan_driver;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] fenshu2;
  logic [3:0] fenshu1;
  logic [3:0] fenshu0;
  logic [3:0] shengming;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks   = 0;
  int failures = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  seg7_scan_driver #(
    .REFRESH_DIV (4),
    .BLANK_CYC   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fenshu2   (fenshu2),
    .fenshu1   (fenshu1),
    .fenshu0   (fenshu0),
    .shengming (shengming),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
               tag, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // Checks n consecutive cycles, sampled on the falling edge.
  task automatic expect_phase(input string tag, input logic [3:0] an_e,
                              input logic [6:0] seg_e, input logic dp_e, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val($sformatf("%s[%0d]", tag, i), {an, seg, dp}, {an_e, seg_e, dp_e});
    end
  endtask

  task automatic expect_off(input string tag, input int n);
    expect_phase(tag, 4'b1111, 7'h7F, 1'b1, n);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    fenshu2 = 4'd0; fenshu1 = 4'd0; fenshu0 = 4'd0; shengming = 4'd0;
    expect_off("reset", 2);

    // 1: life 3, score 257
    rst = 1'b0; en = 1'b1;
    shengming = 4'd3; fenshu2 = 4'd2; fenshu1 = 4'd5; fenshu0 = 4'd7;
    expect_off("t1_lead", 2);
    expect_phase("t1_ones", 4'b1110, 7'h78, 1'b1, 4);
    expect_off("t1_b0", 2);
    expect_phase("t1_tens", 4'b1101, 7'h12, 1'b1, 4);
    expect_off("t1_b1", 2);
    expect_phase("t1_hund", 4'b1011, 7'h24, 1'b1, 4);
    expect_off("t1_b2", 2);
    expect_phase("t1_life", 4'b0111, 7'h30, 1'b0, 4);
    expect_off("t1_b3", 2);

    // 2: ones input changes mid-frame, visible only after the wrap
    expect_phase("t2_ones", 4'b1110, 7'h78, 1'b1, 4);
    expect_off("t2_b0", 2);
    expect_phase("t2_tens_a", 4'b1101, 7'h12, 1'b1, 2);
    fenshu0 = 4'd1;
    expect_phase("t2_tens_b", 4'b1101, 7'h12, 1'b1, 2);
    expect_off("t2_b1", 2);
    expect_phase("t2_hund", 4'b1011, 7'h24, 1'b1, 4);
    expect_off("t2_b2", 2);
    expect_phase("t2_life", 4'b0111, 7'h30, 1'b0, 4);
    expect_off("t2_b3", 2);
    expect_phase("t2_ones_new_a", 4'b1110, 7'h79, 1'b1, 2);

    // 3: invalid BCD mid-digit: no tearing, dash on the next frame
    fenshu0 = 4'hC;
    expect_phase("t3_ones_hold", 4'b1110, 7'h79, 1'b1, 2);
    expect_off("t3_b0", 2);
    expect_phase("t3_tens", 4'b1101, 7'h12, 1'b1, 4);
    expect_off("t3_b1", 2);
    expect_phase("t3_hund", 4'b1011, 7'h24, 1'b1, 4);
    expect_off("t3_b2", 2);
    expect_phase("t3_life", 4'b0111, 7'h30, 1'b0, 4);
    expect_off("t3_b3", 2);
    expect_phase("t3_dash", 4'b1110, 7'h3F, 1'b1, 4);
    expect_off("t3_b4", 2);
    expect_phase("t3_tens2", 4'b1101, 7'h12, 1'b1, 4);
    expect_off("t3_b5", 2);
    expect_phase("t3_hund2", 4'b1011, 7'h24, 1'b1, 2);

    // 4: disable mid-SHOW of hundreds, re-enable restarts at ones
    en = 1'b0;
    expect_off("t4_dark", 3);
    fenshu1 = 4'd8;
    en = 1'b1;
    expect_off("t4_lead", 2);
    expect_phase("t4_ones", 4'b1110, 7'h3F, 1'b1, 4);
    expect_off("t4_b0", 2);
    expect_phase("t4_tens", 4'b1101, 7'h00, 1'b1, 4);
    expect_off("t4_b1", 1);

    // 5: reset pulse mid-BLANK with en held high
    rst = 1'b1;
    fenshu2 = 4'd0; fenshu1 = 4'd0; fenshu0 = 4'd0; shengming = 4'd0;
    expect_off("t5_rst", 1);
    rst = 1'b0;
    expect_off("t5_lead", 2);
    expect_phase("t5_ones", 4'b1110, 7'h40, 1'b1, 4);
    expect_off("t5_b0", 2);
    expect_phase("t5_tens", 4'b1101, LZ, 1'b1, 4);
    expect_off("t5_b1", 2);
    expect_phase("t5_hund", 4'b1011, LZ, 1'b1, 4);
    expect_off("t5_b2", 2);
    expect_phase("t5_life_a", 4'b0111, 7'h40, 1'b0, 2);

    // 6: score 009, life 3
    fenshu0 = 4'd9; shengming = 4'd3;
    expect_phase("t5_life_b", 4'b0111, 7'h40, 1'b0, 2);
    expect_off("t5_b3", 2);
    expect_phase("t6_ones", 4'b1110, 7'h10, 1'b1, 4);
    expect_off("t6_b0", 2);
    expect_phase("t6_tens", 4'b1101, LZ, 1'b1, 4);
    expect_off("t6_b1", 2);
    expect_phase("t6_hund", 4'b1011, LZ, 1'b1, 4);
    expect_off("t6_b2", 2);
    expect_phase("t6_life", 4'b0111, 7'h30, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
